// File: rtl/demux_1ton_sipo.sv
// Serial-in, parallel-out 1-to-N demultiplexer: steers accepted bits into out[sel]
// and presents the completed word with a valid/ready handshake.
module demux_1ton_sipo #(
    parameter  int unsigned N = 8,
    localparam int unsigned M = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in,
    input  logic         in_valid,
    input  logic         start,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic [M-1:0] sel,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [M-1:0] SEL_LAST = M'(N - 1);

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   out_d;
    logic [M-1:0]   sel_d;
    logic           out_valid_d;
    logic           busy_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            sel       <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            sel       <= sel_d;
            busy      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL: begin
                if (!start && in_valid && (sel == SEL_LAST)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = start ? FILL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        out_d       = out;
        sel_d       = sel;
        out_valid_d = out_valid;
        case (state_q)
            IDLE: begin
                if (start) begin
                    out_d = '0;
                    sel_d = '0;
                end
            end
            FILL: begin
                if (start) begin
                    // restart drops this cycle's bit along with the partial word
                    out_d = '0;
                    sel_d = '0;
                end else if (in_valid) begin
                    out_d[sel] = in;
                    if (sel == SEL_LAST) begin
                        sel_d       = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        sel_d = sel + M'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        out_d = '0;
                        sel_d = '0;
                    end
                end
            end
            default: begin
                out_d       = '0;
                sel_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == FILL);
    end

endmodule

// File: tb/tb_demux_1ton_sipo.sv
// Bench for demux_1ton_sipo: directed N=4 scenarios plus randomized N=5 traffic
// checked against a queue-based reference model.
module tb_demux_1ton_sipo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_in = 1'b0, a_iv = 1'b0, a_st = 1'b0, a_rdy = 1'b0;
    logic [3:0] a_out;
    logic       a_ov, a_busy;
    logic [1:0] a_sel;

    logic       b_in = 1'b0, b_iv = 1'b0, b_st = 1'b0, b_rdy = 1'b0;
    logic [4:0] b_out;
    logic       b_ov, b_busy;
    logic [2:0] b_sel;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    demux_1ton_sipo #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in(a_in), .in_valid(a_iv), .start(a_st),
        .out_ready(a_rdy), .out(a_out), .out_valid(a_ov), .sel(a_sel), .busy(a_busy)
    );

    demux_1ton_sipo #(.N(5)) u5 (
        .clk(clk), .rst_n(rst_n), .in(b_in), .in_valid(b_iv), .start(b_st),
        .out_ready(b_rdy), .out(b_out), .out_valid(b_ov), .sel(b_sel), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] o, input logic v,
                        input logic [1:0] s, input logic b);
        check({tag, ".out"},   8'(a_out),  8'(o));
        check({tag, ".valid"}, 8'(a_ov),   8'(v));
        check({tag, ".sel"},   8'(a_sel),  8'(s));
        check({tag, ".busy"},  8'(a_busy), 8'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one bit on the N=4 instance with in_valid high for a single cycle
    task automatic send4(input logic bitv);
        a_iv = 1'b1; a_in = bitv;
        tick();
        a_iv = 1'b0; a_in = 1'b0;
    endtask

    // Reference model for the N=5 instance
    logic       m_active, m_done;
    logic       m_q[$];
    logic [4:0] m_word;

    task automatic model_step(input logic st, input logic iv, input logic bitv, input logic rdy);
        if (m_done) begin
            if (rdy) begin
                m_done = 1'b0;
                if (st) begin m_active = 1'b1; m_q.delete(); m_word = '0; end
            end
        end else if (m_active) begin
            if (st) begin
                m_q.delete(); m_word = '0;
            end else if (iv) begin
                m_q.push_back(bitv);
                m_word = '0;
                foreach (m_q[i]) m_word[i] = m_q[i];
                if (m_q.size() == 5) begin
                    m_active = 1'b0; m_done = 1'b1; m_q.delete();
                end
            end
        end else if (st) begin
            m_active = 1'b1; m_q.delete(); m_word = '0;
        end
    endtask

    initial begin
        logic [1:0] sel_hold;
        logic       st, iv, bv, rdy;

        // Reset applied without any clock edge
        #2;
        chk4("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        check("reset5.out", 8'(b_out), 8'h00);
        rst_n = 1'b1;
        tick();

        // IDLE ignores in_valid
        a_iv = 1'b1; a_in = 1'b1;
        tick(); tick();
        chk4("idle_ignore", 4'b0000, 1'b0, 2'd0, 1'b0);
        a_iv = 1'b0; a_in = 1'b0;

        // Basic capture 1,0,1,1
        a_st = 1'b1; tick(); a_st = 1'b0;
        chk4("basic_start", 4'b0000, 1'b0, 2'd0, 1'b1);
        send4(1'b1);
        chk4("basic_b0", 4'b0001, 1'b0, 2'd1, 1'b1);
        send4(1'b0); send4(1'b1);
        chk4("basic_b2", 4'b0101, 1'b0, 2'd3, 1'b1);
        send4(1'b1);
        chk4("basic_done", 4'b1101, 1'b1, 2'd0, 1'b0);
        a_iv = 1'b1; a_in = 1'b0;
        tick(); tick();
        a_iv = 1'b0;
        chk4("basic_hold", 4'b1101, 1'b1, 2'd0, 1'b0);
        a_rdy = 1'b1; tick(); a_rdy = 1'b0;
        chk4("basic_accept", 4'b1101, 1'b0, 2'd0, 1'b0);

        // Same stream with gaps between bits
        a_st = 1'b1; tick(); a_st = 1'b0;
        chk4("gap_start", 4'b0000, 1'b0, 2'd0, 1'b1);
        send4(1'b1); tick();
        send4(1'b0); tick(); tick();
        sel_hold = a_sel;
        check("gap_sel_frozen", 8'(sel_hold), 8'd2);
        send4(1'b1); tick();
        chk4("gap_mid", 4'b0101, 1'b0, 2'd3, 1'b1);
        send4(1'b1);
        chk4("gap_done", 4'b1101, 1'b1, 2'd0, 1'b0);
        a_rdy = 1'b1; tick(); a_rdy = 1'b0;

        // Restart after two bits; the restart cycle's bit is dropped
        a_st = 1'b1; tick(); a_st = 1'b0;
        send4(1'b1); send4(1'b1);
        a_st = 1'b1; a_iv = 1'b1; a_in = 1'b1;
        tick();
        a_st = 1'b0; a_iv = 1'b0; a_in = 1'b0;
        chk4("restart", 4'b0000, 1'b0, 2'd0, 1'b1);
        send4(1'b0); send4(1'b0); send4(1'b1); send4(1'b0);
        chk4("restart_done", 4'b0100, 1'b1, 2'd0, 1'b0);

        // Stall for three cycles, start during stall ignored
        tick();
        chk4("stall1", 4'b0100, 1'b1, 2'd0, 1'b0);
        a_st = 1'b1; tick(); a_st = 1'b0;
        chk4("stall2", 4'b0100, 1'b1, 2'd0, 1'b0);
        tick();
        chk4("stall3", 4'b0100, 1'b1, 2'd0, 1'b0);
        a_st = 1'b1; a_rdy = 1'b1; tick(); a_st = 1'b0; a_rdy = 1'b0;
        chk4("b2b_fill", 4'b0000, 1'b0, 2'd0, 1'b1);
        send4(1'b1); send4(1'b1); send4(1'b1); send4(1'b0);
        chk4("b2b_done", 4'b0111, 1'b1, 2'd0, 1'b0);
        a_rdy = 1'b1; tick(); a_rdy = 1'b0;

        // Asynchronous reset mid-FILL
        a_st = 1'b1; tick(); a_st = 1'b0;
        send4(1'b1); send4(1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk4("async_rst", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk4("post_rst_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
        a_st = 1'b1; tick(); a_st = 1'b0;
        send4(1'b0); send4(1'b1); send4(1'b1); send4(1'b0);
        chk4("post_rst_word", 4'b0110, 1'b1, 2'd0, 1'b0);

        // Randomized traffic on the N=5 instance
        m_active = 1'b0; m_done = 1'b0; m_word = '0; m_q.delete();
        for (int c = 0; c < 400; c++) begin
            st  = ($urandom_range(0, 9) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            bv  = 1'($urandom);
            rdy = 1'($urandom);
            b_st = st; b_iv = iv; b_in = bv; b_rdy = rdy;
            model_step(st, iv, bv, rdy);
            tick();
            check("r5.out",   8'(b_out),  8'(m_word));
            check("r5.valid", 8'(b_ov),   8'(m_done));
            check("r5.sel",   8'(b_sel),  8'(m_q.size()));
            check("r5.busy",  8'(b_busy), 8'(m_active));
            check("r5.sel_range", 8'(b_sel < 3'd5), 8'd1);
        end
        b_st = 1'b0; b_iv = 1'b0; b_rdy = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
